// File: rtl/wb_coproc_pkg.sv
// wb_coproc_pkg: coprocessor window addresses, opcodes, sequencer states and opcode-to-address mapping
package wb_coproc_pkg;
  localparam logic [4:0] ADR_OPA = 5'h00;
  localparam logic [4:0] ADR_OPB = 5'h04;
  localparam logic [4:0] ADR_SLL = 5'h08;
  localparam logic [4:0] ADR_SRL = 5'h0C;
  localparam logic [4:0] ADR_SRA = 5'h10;
  localparam logic [4:0] ADR_AND = 5'h14;
  localparam logic [4:0] ADR_OR  = 5'h18;
  localparam logic [4:0] ADR_XOR = 5'h1C;
  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD, RSP} state_t;
  function automatic logic [4:0] op_adr(input logic [2:0] op);
    return op == OP_SLL ? ADR_SLL : op == OP_SRL ? ADR_SRL : op == OP_SRA ? ADR_SRA :
           op == OP_AND ? ADR_AND : op == OP_OR  ? ADR_OR  : ADR_XOR;
  endfunction
endpackage

// File: rtl/wb_coproc_opcache.sv
// wb_coproc_opcache: two-entry operand cache (clk, rst, flush, wr_a/wr_b with wdat, cmp_a/cmp_b -> hit_a/hit_b)
module wb_coproc_opcache (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        wr_a,
  input  logic        wr_b,
  input  logic [31:0] wdat,
  input  logic [31:0] cmp_a,
  input  logic [31:0] cmp_b,
  output logic        hit_a,
  output logic        hit_b
);
  logic [31:0] a_q, b_q;
  logic        va, vb;
  assign hit_a = va && a_q == cmp_a;
  assign hit_b = vb && b_q == cmp_b;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      va  <= 1'b0;
      vb  <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (wr_a) begin
        va  <= 1'b1;
        a_q <= wdat;
      end
      if (wr_b) begin
        vb  <= 1'b1;
        b_q <= wdat;
      end
    end
  end
endmodule

// File: rtl/wb_coproc_seq.sv
// wb_coproc_seq: Wishbone master sequencing operand writes and result read (cmd_* in, rsp_* out, wb_* master, cache_flush_i)
module wb_coproc_seq
  import wb_coproc_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_flush_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_op_i,
  input  logic [31:0] cmd_a_i,
  input  logic [31:0] cmd_b_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);
  state_t      state, state_n;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [7:0]  cnt;
  logic        bus, tmo, accept, legal, hit_a, hit_b;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign legal       = cmd_op_i <= OP_XOR;
  assign bus         = state == WR_A || state == WR_B || state == RD;
  assign tmo         = bus && !wb_ack_i && cnt == 8'(TIMEOUT - 1);
  assign cmd_ready_o = state == IDLE;
  assign rsp_valid_o = state == RSP;
  assign wb_cyc_o    = bus;
  assign wb_stb_o    = bus;
  assign wb_we_o     = state == WR_A || state == WR_B;
  assign wb_adr_o    = state == WR_A ? ADR_OPA : state == WR_B ? ADR_OPB : state == RD ? op_adr(op_q) : 5'h00;
  assign wb_dat_o    = state == WR_A ? a_q : state == WR_B ? b_q : 32'h0;
  wb_coproc_opcache u_cache (
    .clk   (clk),
    .rst   (rst),
    .flush (cache_flush_i || tmo),
    .wr_a  (state == WR_A && wb_ack_i),
    .wr_b  (state == WR_B && wb_ack_i),
    .wdat  (wb_dat_o),
    .cmp_a (state == IDLE ? cmd_a_i : a_q),
    .cmp_b (state == IDLE ? cmd_b_i : b_q),
    .hit_a (hit_a),
    .hit_b (hit_b)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !accept ? IDLE : !legal ? RSP : !hit_a ? WR_A : !hit_b ? WR_B : RD;
      WR_A:    state_n = tmo ? RSP : !wb_ack_i ? WR_A : !hit_b ? WR_B : RD;
      WR_B:    state_n = tmo ? RSP : wb_ack_i ? RD : WR_B;
      RD:      state_n = tmo || wb_ack_i ? RSP : RD;
      RSP:     state_n = rsp_ready_i ? IDLE : RSP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt        <= '0;
      rsp_data_o <= '0;
      rsp_err_o  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= bus && state_n == state ? cnt + 8'd1 : 8'd0;
      if (accept) begin
        op_q       <= cmd_op_i;
        a_q        <= cmd_a_i;
        b_q        <= cmd_b_i;
        rsp_data_o <= '0;
        rsp_err_o  <= !legal;
      end
      if (state == RD && wb_ack_i) rsp_data_o <= wb_dat_i;
      if (tmo) begin
        rsp_data_o <= '0;
        rsp_err_o  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_wb_coproc_seq.sv
// tb_wb_coproc_seq: directed and random commands against a coprocessor slave model with a cache-aware reference
module tb_wb_coproc_seq;
  localparam int TIMEOUT = 16;
  logic        clk = 0, rst = 1, cache_flush = 0, cmd_valid = 0, rsp_ready = 0;
  logic [2:0]  cmd_op = 0;
  logic [31:0] cmd_a = 0, cmd_b = 0;
  logic        cmd_ready_o, rsp_valid_o, rsp_err_o, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] rsp_data_o, wb_dat_o;
  logic [4:0]  wb_adr_o;
  logic        s_ack = 0, ack_en = 1;
  logic [31:0] s_dat = 0, opa = 0, opb = 0;
  logic [37:0] log_q[$];
  int          tests = 0, fails = 0;
  logic        mva = 0, mvb = 0;
  logic [31:0] ma = 0, mb = 0, last_d;
  int          last_lat;

  wb_coproc_seq #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cache_flush_i(cache_flush),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(s_dat), .wb_ack_i(s_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_res(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      0: return a << b[4:0];
      1: return a >> b[4:0];
      2: return 32'($signed(a) >>> b[4:0]);
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) s_ack <= 1'b0;
    else s_ack <= ack_en && wb_cyc_o && wb_stb_o && !s_ack;
    if (wb_cyc_o && wb_stb_o && !s_ack && !wb_we_o && wb_adr_o >= 5'h08)
      s_dat <= ref_res((int'(wb_adr_o) - 8) / 4, opa, opb);
    if (wb_cyc_o && wb_stb_o && s_ack && wb_we_o) begin
      if (wb_adr_o == 5'h00) opa <= wb_dat_o;
      if (wb_adr_o == 5'h04) opb <= wb_dat_o;
    end
  end

  always @(posedge clk)
    if (wb_cyc_o && wb_stb_o && s_ack) log_q.push_back({wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : s_dat});

  task automatic chk(input string tag, input logic [37:0] obs, input logic [37:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 38'(cmd_ready_o), 38'd1);
    chk({tag, "_rsp"}, {rsp_valid_o, rsp_err_o, rsp_data_o}, 38'd0);
    chk({tag, "_wb"}, {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o}, 38'd0);
    chk({tag, "_dat"}, 38'(wb_dat_o), 38'd0);
  endtask

  task automatic run_cmd(input string tag, input int op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input int flush_at);
    logic [37:0] exp_q[$];
    logic [31:0] exp_d;
    logic        exp_e;
    int          lat, n;
    if (op < 6 && ack_en) begin
      if (!(mva && ma == a)) exp_q.push_back({1'b1, 5'h00, a});
      if (!(mvb && mb == b)) exp_q.push_back({1'b1, 5'h04, b});
      exp_q.push_back({1'b0, 5'(8 + 4 * op), ref_res(op, a, b)});
    end
    lat   = op >= 6 ? 1 : !ack_en ? TIMEOUT + 1 : 1 + 2 * exp_q.size();
    exp_d = op < 6 && ack_en ? ref_res(op, a, b) : 32'h0;
    exp_e = op >= 6 || !ack_en;
    log_q.delete();
    cmd_op = 3'(op); cmd_a = a; cmd_b = b; cmd_valid = 1;
    chk({tag, "_ready"}, 38'(cmd_ready_o), 38'd1);
    @(posedge clk); #1;
    cmd_valid = 0;
    n = 1;
    while (!rsp_valid_o && n < 300) begin
      cache_flush = n == flush_at;
      @(posedge clk); #1;
      n++;
    end
    cache_flush = 0;
    chk({tag, "_lat"}, 38'(n), 38'(lat));
    chk({tag, "_data"}, 38'(rsp_data_o), 38'(exp_d));
    chk({tag, "_err"}, 38'(rsp_err_o), 38'(exp_e));
    chk({tag, "_busy"}, {cmd_ready_o, wb_cyc_o}, 38'd0);
    repeat (hold) begin
      @(posedge clk); #1;
      chk({tag, "_hold"}, {cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o}, {1'b0, 1'b1, exp_e, exp_d});
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk({tag, "_ntr"}, 38'(log_q.size()), 38'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) chk({tag, "_tr"}, log_q[i], exp_q[i]);
    if (op < 6 && ack_en) begin
      mva = 1; ma = a; mvb = 1; mb = b;
    end
    if (op < 6 && !ack_en) begin
      mva = 0; mvb = 0;
    end
    if (flush_at > 0) begin
      mva = 0; mvb = 0;
    end
    last_d = rsp_data_o;
    last_lat = n;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 0;
    @(posedge clk); #1;
    run_cmd("xor", 5, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0);
    chk("xor_lit", 38'(last_d), 38'h0FF00FF00);
    chk("xor_lat7", 38'(last_lat), 38'd7);
    run_cmd("or", 4, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0);
    chk("or_lit", 38'(last_d), 38'h0FFF0FFF0);
    chk("or_lat3", 38'(last_lat), 38'd3);
    run_cmd("and", 3, 32'h12345678, 32'h0FF00FF0, 0, 0);
    chk("and_lat5", 38'(last_lat), 38'd5);
    run_cmd("ill6", 6, 32'h1, 32'h2, 0, 0);
    chk("ill6_lat1", 38'(last_lat), 38'd1);
    run_cmd("ill7", 7, 32'h12345678, 32'h0FF00FF0, 0, 0);
    ack_en = 0;
    run_cmd("tmo", 5, 32'h12345678, 32'h0FF00FF0, 0, 0);
    ack_en = 1;
    run_cmd("after_tmo", 5, 32'h12345678, 32'h0FF00FF0, 0, 0);
    chk("after_tmo_lat7", 38'(last_lat), 38'd7);
    run_cmd("hold", 1, 32'h80000001, 32'h0FF00FF0, 10, 0);
    run_cmd("flush", 0, 32'hA5A5A5A5, 32'h00000003, 0, 4);
    run_cmd("after_flush", 0, 32'hA5A5A5A5, 32'h00000003, 0, 0);
    chk("after_flush_lat7", 38'(last_lat), 38'd7);
    log_q.delete();
    cmd_op = 3'd2; cmd_a = 32'h80000000; cmd_b = 32'h4; cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("rd_state", {wb_cyc_o, wb_we_o, wb_adr_o}, {1'b1, 1'b0, 5'h10});
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk_reset_outputs("midrst");
    mva = 0; mvb = 0;
    run_cmd("after_rst", 2, 32'h80000000, 32'h4, 0, 0);
    chk("after_rst_lat7", 38'(last_lat), 38'd7);
    for (int k = 0; k < 40; k++) begin
      int          op;
      logic [31:0] a, b;
      op = $urandom_range(0, 7);
      a  = $urandom_range(0, 2) == 0 ? ma : $urandom;
      b  = $urandom_range(0, 2) == 0 ? mb : $urandom;
      ack_en = $urandom_range(0, 9) != 0;
      run_cmd("rnd", op, a, b, $urandom_range(0, 3), 0);
    end
    ack_en = 1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
